// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared defaults for the fetch sequencer: address/instruction widths and the
// sequential PC step.
package pc_fetch_ctrl_pkg;

  localparam int CPU_WIDTH   = 32;
  localparam int INST_W_DEF  = 32;
  localparam int PC_STEP_DEF = 4;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: drives next_pc into the PC register, runs a single-outstanding
// req/gnt/rvalid fetch to instruction memory and hands instructions to decode.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W  = CPU_WIDTH,
  parameter int INST_W  = INST_W_DEF,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [ADDR_W-1:0] curr_pc,
  output logic [ADDR_W-1:0] next_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              halted
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DELIV = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  state_t              state_q, state_d;
  logic                kill_q, kill_d;
  logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;
  logic [INST_W-1:0]   inst_q;
  logic                inst_ld;
  logic [ADDR_W-1:0]   pc_inc;

  // Truncating add: the top of the address space wraps to zero.
  assign pc_inc = curr_pc + STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      kill_q    <= 1'b0;
      pend_pc_q <= '0;
      inst_q    <= '0;
    end else begin
      state_q   <= state_d;
      kill_q    <= kill_d;
      pend_pc_q <= pend_pc_d;
      if (inst_ld) inst_q <= imem_rdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    pend_pc_d = pend_pc_q;
    inst_ld   = 1'b0;
    next_pc   = curr_pc;
    case (state_q)
      IDLE: begin
        if (ena) state_d = REQ;
      end
      REQ: begin
        // Address may change before grant; a redirect coinciding with the
        // grant turns the accepted fetch into a killed one.
        if (redirect_valid) next_pc = redirect_pc;
        if (imem_gnt) begin
          state_d = WAIT;
          if (redirect_valid) begin
            kill_d    = 1'b1;
            pend_pc_d = redirect_pc;
          end
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          kill_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end
        if (imem_rvalid) begin
          if (kill_q || redirect_valid) begin
            next_pc = redirect_valid ? redirect_pc : pend_pc_q;
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_ld = 1'b1;
            state_d = DELIV;
          end
        end
      end
      DELIV: begin
        if (redirect_valid) begin
          next_pc = redirect_pc;
          state_d = REQ;
        end else if (inst_ready) begin
          next_pc = pc_inc;
          state_d = halt_req ? HALT : REQ;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          next_pc = redirect_pc;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs come straight from the state register.
  assign imem_req   = (state_q == REQ);
  assign inst_valid = (state_q == DELIV);
  assign halted     = (state_q == HALT);
  assign imem_addr  = curr_pc;
  assign inst_pc    = curr_pc;
  assign inst       = inst_q;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Fetch sequencer for the program counter register. It drives that register's next_pc input every cycle and runs a single-outstanding request/grant/response handshake to instruction memory. It delivers fetched instructions to decode through a valid/ready handshake. It also handles branch/jump redirects (including killing an in-flight fetch), stall back-pressure and halt.

Parameters:
- ADDR_W, `CPU_WIDTH (32): PC / instruction-address width.
- INST_W, 32: instruction width.
- PC_STEP, 4: sequential PC increment in bytes.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  system enable from the PC register; 0 for the first cycle after reset.
- curr_pc  in  ADDR_W  current PC from the PC register.
- next_pc  out  ADDR_W  combinational next PC, fed to the PC register.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address; equals curr_pc.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid; latency ≥1 cycle after gnt.
- imem_rdata  in  INST_W  read data.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts the instruction.
- inst  out  INST_W  registered instruction.
- inst_pc  out  ADDR_W  PC of inst; equals curr_pc.
- redirect_valid  in  1  branch/jump/trap redirect from execute.
- redirect_pc  in  ADDR_W  redirect target.
- halt_req  in  1  stop after the current instruction is accepted.
- halted  out  1  core halted.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, kill=0, pend_pc=0, inst=0, inst_valid=0, imem_req=0, halted=0.
- Default output: next_pc=curr_pc, i.e. the PC holds.
- Output decode: imem_req, inst_valid and halted are decoded from the registered state only, so they are glitch-free.
- PC arithmetic: curr_pc+PC_STEP is truncated to ADDR_W, so 0xFFFFFFFC+4 wraps to 0x00000000.
- IDLE: wait for ena=1, then go to REQ. Redirects are ignored in IDLE.
- REQ: imem_req=1.
  - gnt without redirect: go to WAIT.
  - gnt with redirect in the same cycle: next_pc=redirect_pc, kill=1, go to WAIT.
  - redirect without gnt: next_pc=redirect_pc, stay in REQ. The imem protocol permits an address change before grant.
- WAIT: imem_req=0.
  - redirect: pend_pc=redirect_pc, kill=1. If several redirects arrive, the last one wins.
  - rvalid with kill=0 and no redirect: inst<=imem_rdata, go to DELIV.
  - rvalid with kill=1 or a redirect in the same cycle: discard the data. next_pc = redirect_pc if a redirect is present this cycle, else pend_pc. Clear kill, go to REQ.
- DELIV: inst_valid=1; inst and inst_pc stay stable while inst_ready=0.
  - Redirect has priority over inst_ready: instruction dropped, next_pc=redirect_pc, go to REQ.
  - inst_ready=1 and halt_req=1: next_pc=curr_pc+PC_STEP, go to HALT.
  - inst_ready=1 and halt_req=0: next_pc=curr_pc+PC_STEP, go to REQ.
- HALT: halted=1, PC holds. A redirect sets next_pc=redirect_pc and goes to REQ; halted drops the next cycle.
- Latency: with 1-cycle memory and ready tied high, one instruction is delivered every 3 cycles (REQ→WAIT→DELIV).
- Reset mid-fetch: state returns to IDLE immediately. A late rvalid is ignored because it can only be consumed in WAIT.
- Error case: a gnt arriving outside REQ is ignored.

Decomposition:
- parameter_defines.v gains `PC_STEP and `INST_W defaults.
- FSM state encoding (IDLE, REQ, WAIT, DELIV, HALT; 3 bits) is local to the module as localparams.
- No sub-module: the FSM, kill/pend_pc tracking and the adder stay in one flat file.
- Bench top connects this block to the existing PC register.

Test Plan:
- Reset → first fetch: release rst_n, 1-cycle memory, ready=1. Required: imem_req with addr 0x0 in the 2nd cycle after ena=1; inst_pc sequence 0x0, 0x4, 0x8, one every 3 cycles.
- Stall: hold inst_ready=0 for 5 cycles in DELIV at pc 0x8. Required: inst and inst_pc=0x8 stable, PC stays 0x8, no imem_req; 0xC is fetched after ready=1.
- Redirect during WAIT: 4-cycle memory, redirect_pc=0x100 one cycle after gnt. Required: returned data discarded, inst_valid stays 0, next fetch addr=0x100.
- Redirect in DELIV with ready=1 at pc 0x20, target 0x40. Required: redirect wins, next imem_addr=0x40 (not 0x24).
- Wrap: redirect to 0xFFFFFFFC, accept the instruction. Required: next fetch addr=0x00000000.
- Halt/resume: halt_req=1 when the instruction at 0x10 is accepted. Required: halted=1, PC=0x14, no requests for 10 cycles. Redirect to 0x80 → halted=0 and a fetch at 0x80.
